// File: rtl/imem_burst_ctrl.sv
// Instruction-memory slave for the I-cache refill port.
// Queues word reads and returns them in order after a fixed latency.
module imem_burst_ctrl #(
  parameter  int MEM_SIZE   = 32768,
  parameter  int LATENCY    = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(MEM_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stb,
  input  logic [AW-1:0] i_addr,
  output logic          o_ack,
  output logic [31:0]   o_data,
  output logic          o_busy,
  output logic          o_ovf,
  output logic          o_err,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] LAT   = CNTW'(LATENCY);
  localparam logic [CW-1:0]   DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [31:0]   mem  [MEM_SIZE/4];
  logic [AW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic [AW-1:0] head;

  logic fire, full, push, drop;
  logic unused;

  assign head    = fifo[rd_ptr];
  assign full    = (count == DEPTH);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push    = i_stb && (!full || fire);
  assign drop    = i_stb && full && !fire;
  assign count_d = count + CW'(push) - CW'(fire);
  assign unused  = ^i_ld_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (count != '0 || push) begin
          state_d = WAIT;
          cnt_d   = CNTW'(1);
        end
      end
      WAIT: begin
        if (fire) begin
          if (count_d != '0) begin
            cnt_d = CNTW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fire   = (state_q == WAIT) && (cnt_q == LAT);
    o_busy = (count != '0) || (state_q != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_ack  <= 1'b0;
      o_data <= '0;
      o_ovf  <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      count <= count_d;
      o_ack <= fire;
      if (fire) begin
        o_data <= (head[1:0] != 2'b00) ? 32'd0 : mem[head[AW-1:2]];
      end
      if (drop) o_ovf <= 1'b1;
      if (i_stb && i_addr[1:0] != 2'b00) o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) fifo[wr_ptr] <= i_addr;
  end

  // Backing store survives reset; reads above see the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_ld_we) mem[i_ld_addr[AW-1:2]] <= i_ld_data;
  end

endmodule
